sargantana_icache_repl_ctrl: RTL and testbench

//  Next-generation I-cache replacement/invalidation controller. Sits between the icache

---
 rtl/sargantana_icache_repl_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_sargantana_icache_repl_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sargantana_icache_repl_ctrl.sv
// I-cache replacement / invalidation controller: victim selection (random, tree-PLRU or
// round-robin), per-set policy state, sequential flush walker and targeted line invalidation.
module sargantana_icache_repl_ctrl #(
    parameter int          ICACHE_N_WAY     = 4,
    parameter int          ICACHE_IDX_WIDTH = 6,
    parameter int          REPL_POLICY      = 0,
    parameter logic [7:0]  LFSR_SEED        = 8'hA5
) (
    input  logic                              clk_i,
    input  logic                              rstn_i,
    input  logic                              flush_i,
    input  logic                              inval_i,
    input  logic [ICACHE_IDX_WIDTH-1:0]       inval_idx_i,
    input  logic [$clog2(ICACHE_N_WAY)-1:0]   inval_way_i,
    input  logic                              cache_rd_ena_i,
    input  logic                              cache_wr_ena_i,
    input  logic [ICACHE_IDX_WIDTH-1:0]       cline_index_i,
    input  logic [ICACHE_N_WAY-1:0]           way_valid_bits_i,
    input  logic                              miss_i,
    input  logic                              hit_i,
    input  logic [$clog2(ICACHE_N_WAY)-1:0]   hit_way_i,
    output logic [$clog2(ICACHE_N_WAY)-1:0]   victim_o,
    output logic [$clog2(ICACHE_N_WAY)-1:0]   victim_q_o,
    output logic                              we_valid_o,
    output logic                              valid_wdata_o,
    output logic [ICACHE_IDX_WIDTH-1:0]       addr_valid_o,
    output logic [ICACHE_N_WAY-1:0]           tag_req_valid_o,
    output logic [ICACHE_N_WAY-1:0]           data_req_valid_o,
    output logic                              flush_busy_o
);
    // state    | meaning
    // ST_IDLE  | serve invalidate / refill write / lookup read
    // ST_FLUSH | walk every set, clearing valid bits and policy state

    localparam int W      = $clog2(ICACHE_N_WAY);
    localparam int N_SETS = 2 ** ICACHE_IDX_WIDTH;
    localparam int N_NODE = ICACHE_N_WAY - 1;

    typedef enum logic {ST_IDLE, ST_FLUSH} state_e;

    state_e                      state_q, state_d;
    logic [ICACHE_IDX_WIDTH-1:0] cnt_q, cnt_d;
    logic [W-1:0]                vic_q, vic_d;
    logic [7:0]                  lfsr_q, lfsr_d;
    logic [N_NODE-1:0]           plru_q [N_SETS];
    logic [N_NODE-1:0]           plru_d [N_SETS];
    logic [W-1:0]                rr_q [N_SETS];
    logic [W-1:0]                rr_d [N_SETS];

    logic                        all_valid;
    logic [W-1:0]                inv_way;
    logic [W-1:0]                pol_way;
    logic                        wr_fire;

    // Tree nodes are heap-ordered; the root decides way bit 0, level l decides way bit l.
    function automatic logic plru_bit(input logic [N_NODE-1:0] tree, input int node);
        logic b;
        b = 1'b0;
        for (int n = 0; n < N_NODE; n++) begin
            if (n == node) b = tree[n];
        end
        return b;
    endfunction

    function automatic logic [W-1:0] plru_walk(input logic [N_NODE-1:0] tree);
        logic [W-1:0] way;
        logic         b;
        int           node;
        way  = '0;
        node = 0;
        for (int l = 0; l < W; l++) begin
            b      = plru_bit(tree, node);
            way[l] = b;
            node   = 2 * node + 1 + (b ? 1 : 0);
        end
        return way;
    endfunction

    function automatic logic [N_NODE-1:0] plru_touch(input logic [N_NODE-1:0] tree,
                                                     input logic [W-1:0]      way);
        logic [N_NODE-1:0] t;
        int                node;
        t    = tree;
        node = 0;
        for (int l = 0; l < W; l++) begin
            for (int n = 0; n < N_NODE; n++) begin
                if (n == node) t[n] = ~way[l];
            end
            node = 2 * node + 1 + (way[l] ? 1 : 0);
        end
        return t;
    endfunction

    always_comb begin
        all_valid = &way_valid_bits_i;
        inv_way   = '0;
        for (int i = ICACHE_N_WAY - 1; i >= 0; i--) begin
            if (!way_valid_bits_i[i]) inv_way = W'(i);
        end
        case (REPL_POLICY)
            1:       pol_way = plru_walk(plru_q[cline_index_i]);
            2:       pol_way = rr_q[cline_index_i];
            default: pol_way = lfsr_q[W-1:0];
        endcase
        victim_o = all_valid ? pol_way : inv_way;
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        vic_d            = vic_q;
        lfsr_d           = lfsr_q;
        plru_d           = plru_q;
        rr_d             = rr_q;
        we_valid_o       = 1'b0;
        valid_wdata_o    = 1'b0;
        addr_valid_o     = '0;
        tag_req_valid_o  = '0;
        data_req_valid_o = '0;
        flush_busy_o     = 1'b0;
        wr_fire          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (flush_i) state_d = ST_FLUSH;
                if (inval_i) begin
                    we_valid_o                   = 1'b1;
                    addr_valid_o                 = inval_idx_i;
                    tag_req_valid_o[inval_way_i] = 1'b1;
                end else if (cache_wr_ena_i) begin
                    wr_fire                       = 1'b1;
                    we_valid_o                    = 1'b1;
                    valid_wdata_o                 = 1'b1;
                    addr_valid_o                  = cline_index_i;
                    tag_req_valid_o[vic_q]        = 1'b1;
                    data_req_valid_o[vic_q]       = 1'b1;
                    plru_d[cline_index_i]         = plru_touch(plru_q[cline_index_i], vic_q);
                    if (all_valid) begin
                        rr_d[cline_index_i] = rr_q[cline_index_i] + W'(1);
                        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                    end
                end else if (cache_rd_ena_i) begin
                    addr_valid_o     = cline_index_i;
                    tag_req_valid_o  = '1;
                    data_req_valid_o = '1;
                end
                // A refill write in the same cycle overrides the hit's PLRU update.
                if (hit_i && !wr_fire) begin
                    plru_d[cline_index_i] = plru_touch(plru_q[cline_index_i], hit_way_i);
                end
                if (miss_i) vic_d = victim_o;
            end
            ST_FLUSH: begin
                flush_busy_o    = 1'b1;
                we_valid_o      = 1'b1;
                addr_valid_o    = cnt_q;
                tag_req_valid_o = '1;
                plru_d[cnt_q]   = '0;
                rr_d[cnt_q]     = '0;
                if (cnt_q == '1) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            vic_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            for (int s = 0; s < N_SETS; s++) begin
                plru_q[s] <= '0;
                rr_q[s]   <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vic_q   <= vic_d;
            lfsr_q  <= lfsr_d;
            plru_q  <= plru_d;
            rr_q    <= rr_d;
        end
    end

    assign victim_q_o = vic_q;

endmodule

// File: tb/tb_sargantana_icache_repl_ctrl.sv
// Bench for sargantana_icache_repl_ctrl: one instance per victim policy, directed steps followed
// by random traffic, all checked against a set-level behavioural model.
module tb_sargantana_icache_repl_ctrl;
    localparam int N    = 4;
    localparam int W    = 2;
    localparam int IDX  = 6;
    localparam int SETS = 64;
    localparam int SEED = 8'hA5;

    logic           clk;
    logic           rstn;
    logic           flush, inval, rd, wr, miss, hit;
    logic [IDX-1:0] inval_idx, cidx;
    logic [W-1:0]   inval_way, hit_way;
    logic [N-1:0]   valid;

    logic [W-1:0]   vic   [3];
    logic [W-1:0]   vicq  [3];
    logic           we    [3];
    logic           wd    [3];
    logic [IDX-1:0] addr  [3];
    logic [N-1:0]   tagr  [3];
    logic [N-1:0]   datar [3];
    logic           busy  [3];

    int nchecks = 0;
    int nerrs   = 0;

    // model state: pb[set][level][prefix of lower way bits] = way bit chosen at that node
    bit pb [SETS][W][N/2];
    int m_rr [SETS];
    int m_lfsr;
    int m_vq [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sargantana_icache_repl_ctrl #(
            .ICACHE_N_WAY(N), .ICACHE_IDX_WIDTH(IDX), .REPL_POLICY(g), .LFSR_SEED(8'hA5)
        ) u_dut (
            .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .inval_i(inval),
            .inval_idx_i(inval_idx), .inval_way_i(inval_way),
            .cache_rd_ena_i(rd), .cache_wr_ena_i(wr), .cline_index_i(cidx),
            .way_valid_bits_i(valid), .miss_i(miss), .hit_i(hit), .hit_way_i(hit_way),
            .victim_o(vic[g]), .victim_q_o(vicq[g]), .we_valid_o(we[g]),
            .valid_wdata_o(wd[g]), .addr_valid_o(addr[g]), .tag_req_valid_o(tagr[g]),
            .data_req_valid_o(datar[g]), .flush_busy_o(busy[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_victim(input int pol, input int vbits, input int idx);
        int v;
        for (int i = 0; i < N; i++) if (((vbits >> i) & 1) == 0) return i;
        case (pol)
            1: begin
                v = 0;
                for (int l = 0; l < W; l++) v = v | (int'(pb[idx][l][v % (1 << l)]) << l);
                return v;
            end
            2:       return m_rr[idx];
            default: return m_lfsr % N;
        endcase
    endfunction

    task automatic m_touch(input int idx, input int w);
        for (int l = 0; l < W; l++) pb[idx][l][w % (1 << l)] = (((w >> l) & 1) == 0);
    endtask

    task automatic m_clear_sets();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int l = 0; l < W; l++) for (int p = 0; p < N/2; p++) pb[s][l][p] = 1'b0;
        end
    endtask

    task automatic m_reset();
        m_clear_sets();
        m_lfsr = SEED;
        for (int d = 0; d < 3; d++) m_vq[d] = 0;
    endtask

    task automatic idle_in();
        flush = 0; inval = 0; rd = 0; wr = 0; miss = 0; hit = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_common(input string tag, input int e_we, input int e_wd, input int e_addr,
                              input int e_busy);
        for (int d = 0; d < 3; d++) begin
            chk({tag, "_we"}, 32'(we[d]), 32'(e_we));
            chk({tag, "_wdata"}, 32'(wd[d]), 32'(e_wd));
            chk({tag, "_addr"}, 32'(addr[d]), 32'(e_addr));
            chk({tag, "_busy"}, 32'(busy[d]), 32'(e_busy));
        end
    endtask

    task automatic chk_victims(input string tag);
        for (int d = 0; d < 3; d++)
            chk(tag, 32'(vic[d]), 32'(m_victim(d, int'(valid), int'(cidx))));
    endtask

    task automatic op_miss(input int idx, input int vbits);
        int e [3];
        idle_in(); cidx = IDX'(idx); valid = N'(vbits); rd = 1; miss = 1;
        #1;
        chk_victims("miss_victim");
        chk_common("rd", 0, 0, idx, 0);
        for (int d = 0; d < 3; d++) begin
            e[d] = m_victim(d, vbits, idx);
            chk("rd_tag", 32'(tagr[d]), 32'hF);
            chk("rd_data", 32'(datar[d]), 32'hF);
        end
        step();
        for (int d = 0; d < 3; d++) begin
            m_vq[d] = e[d];
            chk("miss_victim_q", 32'(vicq[d]), 32'(m_vq[d]));
        end
        idle_in();
    endtask

    task automatic op_hit(input int idx, input int w);
        idle_in(); cidx = IDX'(idx); valid = '1; rd = 1; hit = 1; hit_way = W'(w);
        #1;
        chk_victims("hit_victim");
        step();
        m_touch(idx, w);
        idle_in();
    endtask

    task automatic op_wr(input int idx, input int vbits, input int with_hit, input int hway);
        idle_in(); cidx = IDX'(idx); valid = N'(vbits); wr = 1;
        rd = (with_hit != 0); hit = (with_hit != 0); hit_way = W'(hway);
        #1;
        chk_victims("wr_victim");
        chk_common("wr", 1, 1, idx, 0);
        for (int d = 0; d < 3; d++) begin
            chk("wr_tag", 32'(tagr[d]), 32'(1 << m_vq[d]));
            chk("wr_data", 32'(datar[d]), 32'(1 << m_vq[d]));
        end
        step();
        m_touch(idx, m_vq[1]);
        if (vbits == 15) begin
            m_rr[idx] = (m_rr[idx] + 1) % N;
            m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^
                     (m_lfsr >> 3)) & 1)) & 255;
        end
        idle_in();
    endtask

    task automatic op_inval(input int iidx, input int iway, input int with_wr, input int c,
                            input int vbits);
        idle_in(); inval = 1; inval_idx = IDX'(iidx); inval_way = W'(iway);
        wr = (with_wr != 0); cidx = IDX'(c); valid = N'(vbits);
        #1;
        chk_victims("inval_victim");
        chk_common("inval", 1, 0, iidx, 0);
        for (int d = 0; d < 3; d++) begin
            chk("inval_tag", 32'(tagr[d]), 32'(1 << iway));
            chk("inval_data", 32'(datar[d]), 32'h0);
        end
        step();
        idle_in();
    endtask

    task automatic op_flush(input int noise);
        idle_in(); flush = 1;
        #1;
        chk("flush_busy_pre", 32'(busy[0]), 32'h0);
        step();
        flush = 0;
        for (int i = 0; i < SETS; i++) begin
            if (noise != 0) begin
                flush = 1'($urandom_range(0, 1)); inval = 1'($urandom_range(0, 1));
                rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
                miss = 1'($urandom_range(0, 1)); hit = 1'($urandom_range(0, 1));
                cidx = IDX'($urandom_range(0, SETS - 1)); valid = N'($urandom_range(0, 15));
                hit_way = W'($urandom_range(0, N - 1));
            end
            #1;
            chk_common("flush", 1, 0, i, 1);
            for (int d = 0; d < 3; d++) begin
                chk("flush_tag", 32'(tagr[d]), 32'hF);
                chk("flush_data", 32'(datar[d]), 32'h0);
            end
            @(posedge clk);
            #1;
        end
        idle_in();
        #1;
        m_clear_sets();
        for (int d = 0; d < 3; d++) begin
            chk("flush_done_busy", 32'(busy[d]), 32'h0);
            chk("flush_victim_q_held", 32'(vicq[d]), 32'(m_vq[d]));
        end
    endtask

    initial begin
        int op, idx, vb;
        rstn = 0;
        idle_in();
        cidx = '0; inval_idx = '0; inval_way = '0; hit_way = '0; valid = '1;
        m_reset();
        repeat (3) step();
        chk_common("reset", 0, 0, 0, 0);
        chk_victims("reset_victim");
        for (int d = 0; d < 3; d++) begin
            chk("reset_victim_q", 32'(vicq[d]), 32'h0);
            chk("reset_tag", 32'(tagr[d]), 32'h0);
        end
        rstn = 1;
        step();

        op_flush(1);

        op_miss(7, 4'b1011);
        for (int d = 0; d < 3; d++) chk("lowest_invalid_victim_q", 32'(vicq[d]), 32'h2);
        op_wr(7, 4'b1011, 0, 0);

        op_hit(5, 0); op_hit(5, 1); op_hit(5, 2);
        op_miss(5, 15);
        chk("plru_after_hits_012", 32'(vicq[1]), 32'h3);

        for (int k = 0; k < 5; k++) begin
            op_miss(9, 15);
            chk("rr_sequence", 32'(vicq[2]), 32'(k % N));
            op_wr(9, 15, 0, 0);
        end

        op_inval(12, 1, 1, 3, 15);
        op_wr(3, 15, 1, 2);

        idle_in(); flush = 1;
        step();
        flush = 0;
        repeat (20) step();
        chk("abort_flush_addr", 32'(addr[0]), 32'd20);
        rstn = 0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("abort_busy", 32'(busy[d]), 32'h0);
            chk("abort_we", 32'(we[d]), 32'h0);
        end
        m_reset();
        step();
        rstn = 1;
        step();
        op_flush(0);

        for (int it = 0; it < 400; it++) begin
            op  = $urandom_range(0, 4);
            idx = $urandom_range(0, SETS - 1);
            vb  = ($urandom_range(0, 1) == 1) ? 15 : $urandom_range(0, 15);
            case (op)
                0: op_miss(idx, vb);
                1: op_hit(idx, $urandom_range(0, N - 1));
                2: op_wr(idx, vb, $urandom_range(0, 1), $urandom_range(0, N - 1));
                3: op_inval($urandom_range(0, SETS - 1), $urandom_range(0, N - 1),
                            $urandom_range(0, 1), idx, vb);
                default: begin
                    op_miss(idx, 15);
                    op_wr(idx, 15, 0, 0);
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule
